// File: rtl/dii_rr_arbiter.sv
// Round-robin arbiter that merges N DII requester channels onto one output channel.
// A requester keeps the grant from its first offered beat until its last beat transfers.
module dii_rr_arbiter #(
   parameter int N = 2,
   parameter int W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_valid,
   input  logic [N-1:0]         in_last,
   input  logic [N*W-1:0]       in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic                 out_last,
   output logic [W-1:0]         out_data,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [$clog2(N)-1:0] grant
);
   localparam int GW = $clog2(N);

   // Handshake: a beat moves on a port in any cycle where its valid and ready are both high;
   // ready never waits on a later cycle, so the winner's in_ready simply mirrors out_ready.
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t        state;
   logic [GW-1:0] ptr;
   logic [GW-1:0] lock_idx;
   logic [GW-1:0] winner;
   logic [GW-1:0] sel;
   logic [GW-1:0] sel_next;
   logic          found;
   logic          xfer_last;

   // Rotating search starting at ptr; the first valid requester wins.
   always_comb begin
      logic [GW:0] s;
      found  = 1'b0;
      winner = '0;
      s      = '0;
      for (int k = 0; k < N; k++) begin
         s = {1'b0, ptr} + (GW+1)'(k);
         if (s >= (GW+1)'(N)) s = s - (GW+1)'(N);
         if (!found && in_valid[s[GW-1:0]]) begin
            found  = 1'b1;
            winner = s[GW-1:0];
         end
      end
   end

   assign sel       = (state == LOCKED) ? lock_idx : winner;
   assign sel_next  = (sel == GW'(N-1)) ? '0 : sel + GW'(1);
   assign grant     = sel;
   assign busy      = (state == LOCKED);
   assign xfer_last = out_valid & out_ready & out_last;

   always_comb begin
      in_ready  = '0;
      out_data  = '0;
      out_valid = (state == LOCKED) ? in_valid[lock_idx] : found;
      out_last  = in_last[sel];
      for (int k = 0; k < N; k++) begin
         if (sel == GW'(k)) out_data = in_data[k*W +: W];
      end
      if (state == LOCKED || found) in_ready[sel] = out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         lock_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  if (xfer_last) begin
                     ptr <= sel_next;
                  end else begin
                     state    <= LOCKED;
                     lock_idx <= winner;
                  end
               end
            end
            LOCKED: begin
               // Only the locked requester's last transfer releases the grant.
               if (xfer_last) begin
                  state <= IDLE;
                  ptr   <= sel_next;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dii_rr_arbiter.sv
// Bench for dii_rr_arbiter: three instances (N=2,3,4) share one stimulus bus and are
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_dii_rr_arbiter;
   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    v;
   logic [7:0]    l;
   logic [127:0]  d;
   logic          ordy;

   logic [1:0]    rdy2;
   logic [2:0]    rdy3;
   logic [3:0]    rdy4;
   logic          ov [3];
   logic          ol [3];
   logic          bz [3];
   logic [15:0]   od [3];
   logic [0:0]    g2;
   logic [1:0]    g3;
   logic [1:0]    g4;

   int            n_pass = 0;
   int            n_total = 0;
   logic          chk_en = 1'b0;
   int            m_locked [3] = '{0, 0, 0};
   int            m_ptr [3]    = '{0, 0, 0};
   int            m_lock [3]   = '{0, 0, 0};
   logic [15:0]   exp_q[$];

   always #5 clk = ~clk;

   dii_rr_arbiter #(.N(2), .W(16)) u2 (
      .clk(clk), .rst(rst), .in_valid(v[1:0]), .in_last(l[1:0]), .in_data(d[31:0]),
      .in_ready(rdy2), .out_valid(ov[0]), .out_last(ol[0]), .out_data(od[0]),
      .out_ready(ordy), .busy(bz[0]), .grant(g2));
   dii_rr_arbiter #(.N(3), .W(16)) u3 (
      .clk(clk), .rst(rst), .in_valid(v[2:0]), .in_last(l[2:0]), .in_data(d[47:0]),
      .in_ready(rdy3), .out_valid(ov[1]), .out_last(ol[1]), .out_data(od[1]),
      .out_ready(ordy), .busy(bz[1]), .grant(g3));
   dii_rr_arbiter #(.N(4), .W(16)) u4 (
      .clk(clk), .rst(rst), .in_valid(v[3:0]), .in_last(l[3:0]), .in_data(d[63:0]),
      .in_ready(rdy4), .out_valid(ov[2]), .out_last(ol[2]), .out_data(od[2]),
      .out_ready(ordy), .busy(bz[2]), .grant(g4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [7:0] get_rdy(input int k);
      case (k)
         0:       return {6'b0, rdy2};
         1:       return {5'b0, rdy3};
         default: return {4'b0, rdy4};
      endcase
   endfunction

   function automatic logic [7:0] get_g(input int k);
      case (k)
         0:       return {7'b0, g2};
         1:       return {6'b0, g3};
         default: return {6'b0, g4};
      endcase
   endfunction

   // Model: locked requester owns the output; otherwise first valid from ptr, wrapping mod n.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            int n, sel, idx;
            logic ev;
            logic [7:0] er;
            n   = k + 2;
            sel = -1;
            if (m_locked[k] != 0) sel = m_lock[k];
            else begin
               for (int j = 0; j < n; j++) begin
                  idx = (m_ptr[k] + j) % n;
                  if (sel < 0 && v[idx]) sel = idx;
               end
            end
            ev = (sel >= 0) ? v[sel] : 1'b0;
            er = '0;
            if (sel >= 0) er[sel] = ordy;
            chk($sformatf("u%0d out_valid", n), 32'(ov[k]), 32'(ev));
            chk($sformatf("u%0d in_ready", n), 32'(get_rdy(k)), 32'(er));
            chk($sformatf("u%0d grant", n), 32'(get_g(k)), (sel < 0) ? 32'd0 : 32'(sel));
            chk($sformatf("u%0d busy", n), 32'(bz[k]), 32'(m_locked[k] != 0));
            if (ev) begin
               chk($sformatf("u%0d out_data", n), 32'(od[k]), 32'(d[sel*16 +: 16]));
               chk($sformatf("u%0d out_last", n), 32'(ol[k]), 32'(l[sel]));
            end
            if (rst) begin
               m_locked[k] = 0; m_ptr[k] = 0; m_lock[k] = 0;
            end else if (sel >= 0) begin
               if (ev && ordy && l[sel]) begin
                  m_locked[k] = 0;
                  m_ptr[k]    = (sel + 1) % n;
               end else if (m_locked[k] == 0) begin
                  m_locked[k] = 1;
                  m_lock[k]   = sel;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input logic [7:0] vv, input logic [7:0] ll, input logic rr);
      v = vv; l = ll; ordy = rr;
   endtask

   task automatic set_d(input int i, input logic [15:0] val);
      d[i*16 +: 16] = val;
   endtask

   // Literal expectations for one instance, checked 2 time units after the inputs change.
   task automatic lit(input string tag, input int k, input int e_ov, input int e_g,
                      input int e_rdy, input int e_bz);
      #2;
      chk({tag, " ov"}, 32'(ov[k]), 32'(e_ov));
      chk({tag, " grant"}, 32'(get_g(k)), 32'(e_g));
      chk({tag, " rdy"}, 32'(get_rdy(k)), 32'(e_rdy));
      chk({tag, " busy"}, 32'(bz[k]), 32'(e_bz));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set(8'h00, 8'h00, 1'b1);
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int beat [4], pkt [4], seq [4], cnt [4];
      int npk, cyc;
      logic [3:0] xf;
      rst = 1'b1; d = '0;
      set(8'h00, 8'h00, 1'b1);
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      lit("reset u2", 0, 0, 0, 0, 0);
      chk("reset u4 grant", 32'(g4), 32'd0);

      // Two always-valid single-beat requesters alternate.
      do_reset();
      set_d(0, 16'hA000); set_d(1, 16'hB001);
      set(8'h03, 8'h03, 1'b1);
      lit("alt c1", 0, 1, 0, 1, 0); chk("alt c1 data", 32'(od[0]), 32'h A000);
      step(); lit("alt c2", 0, 1, 1, 2, 0); chk("alt c2 data", 32'(od[0]), 32'h B001);
      step(); lit("alt c3", 0, 1, 0, 1, 0);
      step(); lit("alt c4", 0, 1, 1, 2, 0);

      // 3-beat packet from req0 holds off req1.
      do_reset();
      set_d(0, 16'hA001); set_d(1, 16'hB001);
      set(8'h03, 8'h02, 1'b1); lit("pkt b1", 0, 1, 0, 1, 0);
      chk("pkt b1 data", 32'(od[0]), 32'h A001);
      step(); set_d(0, 16'hA002); lit("pkt b2", 0, 1, 0, 1, 1);
      step(); set_d(0, 16'hA003); set(8'h03, 8'h03, 1'b1); lit("pkt b3", 0, 1, 0, 1, 1);
      chk("pkt b3 last", 32'(ol[0]), 32'd1);
      step(); set(8'h02, 8'h02, 1'b1); lit("pkt req1", 0, 1, 1, 2, 0);
      chk("pkt req1 data", 32'(od[0]), 32'h B001);

      // N=3: req2 stalled, req0 arrives, grant held.
      do_reset();
      set_d(2, 16'hC001); set_d(0, 16'hC100);
      set(8'h04, 8'h04, 1'b0); lit("stall c1", 1, 1, 2, 0, 0);
      step(); set(8'h05, 8'h05, 1'b0); lit("stall c2", 1, 1, 2, 0, 1);
      step(); lit("stall c3", 1, 1, 2, 0, 1);
      step(); set(8'h05, 8'h05, 1'b1); lit("stall c4", 1, 1, 2, 4, 1);
      step(); set(8'h03, 8'h03, 1'b1); lit("stall next", 1, 1, 0, 1, 0);

      // Bubbles inside a locked packet.
      do_reset();
      set_d(1, 16'hD001); set_d(0, 16'hD100);
      set(8'h02, 8'h00, 1'b1); lit("bub b1", 0, 1, 1, 2, 0);
      step(); set(8'h01, 8'h01, 1'b1); lit("bub gap1", 0, 0, 1, 2, 1);
      step(); lit("bub gap2", 0, 0, 1, 2, 1);
      step(); set_d(1, 16'hD002); set(8'h03, 8'h01, 1'b1); lit("bub b2", 0, 1, 1, 2, 1);
      chk("bub b2 data", 32'(od[0]), 32'h D002);
      step(); set_d(1, 16'hD003); set(8'h03, 8'h03, 1'b1); lit("bub b3", 0, 1, 1, 2, 1);
      chk("bub b3 last", 32'(ol[0]), 32'd1);
      step(); set(8'h01, 8'h01, 1'b1); lit("bub after", 0, 1, 0, 1, 0);

      // Reset on beat 2 of a 4-beat packet from req1.
      do_reset();
      set_d(1, 16'hE001); set(8'h02, 8'h00, 1'b1); lit("rstmid b1", 0, 1, 1, 2, 0);
      step(); set_d(1, 16'hE002); rst = 1'b1;
      step(); rst = 1'b0; set(8'h03, 8'h03, 1'b1); lit("rstmid after", 0, 1, 0, 1, 0);

      // Single requester streams back-to-back single-beat packets.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_d(0, 16'(16'hF000 + c)); set(8'h01, 8'h01, 1'b1);
         lit($sformatf("single c%0d", c), 0, 1, 0, 1, 0);
         step();
      end

      // N=4 fairness with random out_ready, scoreboarded beat by beat.
      do_reset();
      for (int i = 0; i < 4; i++) begin beat[i] = 0; pkt[i] = 0; seq[i] = 0; cnt[i] = 0; end
      npk = 0; cyc = 0;
      while (npk < 400 && cyc < 20000) begin
         for (int i = 0; i < 4; i++) begin
            l[i] = (beat[i] == ((i + pkt[i]) % 3));
            set_d(i, {4'(i), 12'(seq[i])});
         end
         v = 8'h0F; ordy = 1'($urandom_range(0, 1));
         #2;
         xf = v[3:0] & rdy4;
         for (int i = 0; i < 4; i++) if (xf[i]) exp_q.push_back(d[i*16 +: 16]);
         if (ov[2] && ordy) begin
            if (exp_q.size() == 0) chk("sb underflow", 32'd1, 32'd0);
            else chk("sb data", 32'(od[2]), 32'(exp_q.pop_front()));
            if (ol[2]) begin cnt[g4]++; npk++; end
         end
         for (int i = 0; i < 4; i++) begin
            if (xf[i]) begin
               seq[i]++;
               if (l[i]) begin beat[i] = 0; pkt[i]++; end
               else beat[i]++;
            end
         end
         step();
         cyc++;
      end
      chk("fair packets done", 32'(npk), 32'd400);
      for (int i = 0; i < 4; i++) chk($sformatf("fair req%0d", i), 32'(cnt[i]), 32'd100);
      chk("sb empty", 32'(exp_q.size()), 32'd0);

      set(8'h00, 8'h00, 1'b1);
      step();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dii_rr_arbiter.md
DII_RR_ARBITER -- requirements
Module: dii_rr_arbiter

Interface
REQ-001 Parameter N, default 2: number of requester DII channels, 2..8.
REQ-002 Parameter W, default 16: DII data width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  N  per-requester beat valid.
REQ-006 in_last  input  N  per-requester last beat of packet.
REQ-007 in_data  input  N*W  requester i data occupies bits [i*W +: W].
REQ-008 in_ready  output  N  per-requester beat accepted.
REQ-009 out_valid  output  1  merged channel beat valid.
REQ-010 out_last  output  1  merged channel last beat.
REQ-011 out_data  output  W  merged channel data.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 busy  output  1  high while the state is LOCKED.
REQ-014 grant  output  $clog2(N)  index of the currently selected requester; 0 when none is selected.

Function
REQ-015 States: IDLE and LOCKED. Registers: ptr (priority pointer), lock_idx.
REQ-016 Transfer on a port: valid & ready both high in the same cycle.
REQ-017 IDLE winner: the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
REQ-018 IDLE with no in_valid: out_valid=0, all in_ready=0, grant=0, state and ptr unchanged.
REQ-019 IDLE with a winner: same cycle, combinationally, out_valid=1, out_data/out_last = winner's data/last, in_ready[winner]=out_ready, all other in_ready=0 (zero-cycle latency).
REQ-020 IDLE winner beat transferred with last=1: stay IDLE; ptr <= (winner+1) mod N.
REQ-021 IDLE winner beat not transferred, or transferred with last=0: go to LOCKED; lock_idx <= winner; ptr unchanged.
REQ-022 LOCKED: the output is driven only from lock_idx. out_valid=in_valid[lock_idx], out_data/out_last from lock_idx, in_ready[lock_idx]=out_ready, all other in_ready=0.
REQ-023 LOCKED: other requesters' in_valid is ignored, so the grant cannot change mid-packet or while a first beat is stalled.
REQ-024 LOCKED, transfer with last=1: go to IDLE; ptr <= (lock_idx+1) mod N.
REQ-025 LOCKED, bubbles (in_valid[lock_idx]=0): stay LOCKED, out_valid=0.
REQ-026 grant equals the winner in IDLE and lock_idx in LOCKED.
REQ-027 When out_valid=0, out_data and out_last are don't-care.
REQ-028 Fairness: with all N requesters continuously valid, each wins exactly once in any N consecutive packets.
REQ-029 Single-requester case: back-to-back single-beat packets sustain 1 beat per cycle with no idle cycle.
REQ-030 The ptr increment wraps from N-1 to 0.

Reset
REQ-031 With rst=1 at a clock edge: state <= IDLE, ptr <= 0, lock_idx <= 0.
REQ-032 During and after reset, outputs follow IDLE rules; with inputs idle, out_valid=0, in_ready=0, busy=0, grant=0.
REQ-033 Reset mid-packet abandons the lock. No tail completion; the next packet is arbitrated from ptr=0.

Verification
REQ-034 N=2, both valid single-beat packets, out_ready=1, 4 cycles -> outputs alternate 0,1,0,1; busy stays 0; every in_ready pulse coincides with its out beat.
REQ-035 N=2, req0 sends a 3-beat packet while req1 is valid throughout -> 3 beats from 0, then req1's packet; in_ready[1]=0 until req0's last beat; busy=1 for beats 2-3.
REQ-036 N=3, req2 valid, out_ready=0 for 3 cycles while req0 becomes valid at cycle 2 -> grant stays 2; req2's beat transfers when out_ready rises; ptr becomes 0.
REQ-037 Locked requester inserts 2 bubble cycles mid-packet -> out_valid=0 for 2 cycles, grant is held, packet completes intact.
REQ-038 Reset asserted on beat 2 of a 4-beat packet from req1 -> next cycle busy=0, ptr=0; with both requesters valid, req0 wins first.
REQ-039 N=4, all valid, random out_ready -> each requester has exactly 25% of 400 packets; no beat is duplicated or dropped (scoreboard).
